// File: rtl/key_event_queue.sv
// rtl/key_event_queue.sv - 8-deep FIFO of key-column indices with pending-bit arbitration
// Presses latch into pending bits, drain lowest index first into the queue, and losses set a sticky flag.
module key_event_queue (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic [7:0] key_interrupt,
    input  logic       rd_en,
    input  logic       clr_ovf,
    output logic [2:0] key_code,
    output logic       key_valid,
    output logic [3:0] fifo_count,
    output logic       overflow,
    output logic       irq
);

    logic [7:0] pending;
    logic [7:0] pending_next;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic [2:0] mem [8];
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic       push_ok;
    logic       push;
    logic       pop;
    logic       lost;
    logic       ovf_next;
    logic [3:0] count_next;

    always_comb begin
        grant_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) begin
                grant_idx = 3'(i);
            end
        end
        // A full queue still accepts a push when the head is popped in the same cycle.
        push_ok      = (fifo_count < 4'd8) | rd_en;
        push         = push_ok & (|pending);
        grant        = push ? (8'd1 << grant_idx) : 8'd0;
        pop          = rd_en & (fifo_count != 4'd0);
        lost         = |(key_interrupt & pending & ~grant);
        ovf_next     = lost | (overflow & ~clr_ovf);
        count_next   = fifo_count + {3'b000, push} - {3'b000, pop};
        pending_next = (pending & ~grant) | key_interrupt;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pending    <= 8'd0;
            wr_ptr     <= 3'd0;
            rd_ptr     <= 3'd0;
            fifo_count <= 4'd0;
            overflow   <= 1'b0;
            irq        <= 1'b0;
        end else begin
            pending    <= pending_next;
            fifo_count <= count_next;
            overflow   <= ovf_next;
            irq        <= (count_next != 4'd0) | ovf_next;
            if (push) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
        end
    end

    // Storage needs no reset; key_code is masked while the queue is empty.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr] <= grant_idx;
        end
    end

    assign key_valid = (fifo_count != 4'd0);
    assign key_code  = key_valid ? mem[rd_ptr] : 3'd0;

endmodule
